prng_multi: RTL

//  Multi-channel XNOR Fibonacci LFSR pseudorandom source with a valid/ready output stream.

---
 rtl/prng_multi_if.sv | 30 +++
 rtl/prng_multi.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/prng_multi_if.sv
// Stream and reseed bundle between the multi-channel PRNG and its consumers.
// master: the PRNG block; slave: the consumer/reseed controller.
interface prng_multi_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int STATE_BITS   = 16,
    parameter int OUTPUT_BITS  = 2
);
    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0]             entropy;
    logic                                out_valid;
    logic                                out_ready;
    logic [NUM_CHANNELS*OUTPUT_BITS-1:0] random;
    logic                                seed_valid;
    logic                                seed_ready;
    logic [CHAN_W-1:0]                   seed_chan;
    logic [STATE_BITS-1:0]               seed_data;
    logic                                warming;
    logic                                lockup;

    modport master (
        input  entropy, out_ready, seed_valid, seed_chan, seed_data,
        output out_valid, random, seed_ready, warming, lockup
    );

    modport slave (
        output entropy, out_ready, seed_valid, seed_chan, seed_data,
        input  out_valid, random, seed_ready, warming, lockup
    );
endinterface

// File: rtl/prng_multi.sv
// Multi-channel XNOR Fibonacci LFSR source with a valid/ready word stream,
// runtime reseeding followed by a warm-up, entropy injection and lock-up guard.
module prng_multi #(
    parameter int                    NUM_CHANNELS = 4,
    parameter int                    STATE_BITS   = 16,
    parameter logic [STATE_BITS-1:0] POLYNOMIAL   = 16'hD008,
    parameter logic [STATE_BITS-1:0] STATE_INIT   = '0,
    parameter int                    OUTPUT_BITS  = 2,
    parameter int                    WARM_CYCLES  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    prng_multi_if.master   bus
);
    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W  = $clog2(WARM_CYCLES + 1);

    typedef enum logic {
        WARM,
        RUN
    } fsm_t;

    fsm_t                  fsm_q;
    logic [CNT_W-1:0]      warm_cnt_q;
    logic [STATE_BITS-1:0] chan_q   [NUM_CHANNELS];
    logic [STATE_BITS-1:0] raw_next [NUM_CHANNELS];
    logic [STATE_BITS-1:0] chan_d   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] load_en;
    logic [NUM_CHANNELS-1:0] guard_hit;
    logic [NUM_CHANNELS*OUTPUT_BITS-1:0] random_w;
    logic                  out_valid_q;
    logic                  seed_ready_q;
    logic                  warming_q;
    logic                  lockup_q;
    logic                  fire;
    logic                  seed_hit;

    function automatic logic [STATE_BITS-1:0] lfsr_step(input logic [STATE_BITS-1:0] s,
                                                        input logic e);
        logic fb;
        fb = (^(s & POLYNOMIAL)) ^ e;
        return {s[STATE_BITS-2:0], ~fb};
    endfunction

    // Entropy only perturbs the first of the chained steps in a word.
    function automatic logic [STATE_BITS-1:0] advance(input logic [STATE_BITS-1:0] s,
                                                      input logic e);
        logic [STATE_BITS-1:0] t;
        t = s;
        for (int k = 0; k < OUTPUT_BITS; k++) begin
            t = lfsr_step(t, (k == 0) ? e : 1'b0);
        end
        return t;
    endfunction

    // All-ones is the XNOR LFSR's stuck state; knock bit0 low to escape it.
    function automatic logic [STATE_BITS-1:0] lockup_guard(input logic [STATE_BITS-1:0] s);
        return (&s) ? {{(STATE_BITS-1){1'b1}}, 1'b0} : s;
    endfunction

    always_comb begin
        fire     = (fsm_q == RUN) && bus.out_ready;
        seed_hit = (fsm_q == RUN) && bus.seed_valid && (int'(bus.seed_chan) < NUM_CHANNELS);
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            raw_next[c] = chan_q[c];
            load_en[c]  = 1'b0;
            if (fsm_q == WARM) begin
                raw_next[c] = advance(chan_q[c], 1'b0);
                load_en[c]  = 1'b1;
            end else begin
                if (fire) begin
                    raw_next[c] = advance(chan_q[c], bus.entropy[c]);
                    load_en[c]  = 1'b1;
                end
                if (seed_hit && (bus.seed_chan == CHAN_W'(c))) begin
                    raw_next[c] = bus.seed_data;
                    load_en[c]  = 1'b1;
                end
            end
            guard_hit[c] = load_en[c] && (&raw_next[c]);
            chan_d[c]    = lockup_guard(raw_next[c]);
        end
    end

    // The MSB before each chained step is simply the next-lower state bit,
    // so the word is the top OUTPUT_BITS of the registered state.
    always_comb begin
        random_w = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            random_w[c*OUTPUT_BITS +: OUTPUT_BITS] = chan_q[c][STATE_BITS-1 -: OUTPUT_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                chan_q[c] <= STATE_INIT ^ STATE_BITS'(c);
            end
            fsm_q        <= WARM;
            warm_cnt_q   <= CNT_W'(WARM_CYCLES);
            out_valid_q  <= 1'b0;
            seed_ready_q <= 1'b0;
            warming_q    <= 1'b1;
            lockup_q     <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                chan_q[c] <= chan_d[c];
            end
            lockup_q <= |guard_hit;
            case (fsm_q)
                WARM: begin
                    if (warm_cnt_q == CNT_W'(1)) begin
                        fsm_q        <= RUN;
                        out_valid_q  <= 1'b1;
                        seed_ready_q <= 1'b1;
                        warming_q    <= 1'b0;
                    end else begin
                        warm_cnt_q <= warm_cnt_q - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (seed_hit) begin
                        fsm_q        <= WARM;
                        warm_cnt_q   <= CNT_W'(WARM_CYCLES);
                        out_valid_q  <= 1'b0;
                        seed_ready_q <= 1'b0;
                        warming_q    <= 1'b1;
                    end
                end
                default: fsm_q <= WARM;
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.seed_ready = seed_ready_q;
    assign bus.warming    = warming_q;
    assign bus.lockup     = lockup_q;
    assign bus.random     = random_w;
endmodule
